// File: rtl/config_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : config_text_writer
// Purpose  : Command sequencer that clears, pokes or copies menu-ROM tiles
//            into the 40x23 configuration tile buffer.
// Revision : 1.0 - initial release
// ============================================================================
module config_text_writer #(
    parameter int COLS        = 40,
    parameter int ROWS        = 23,
    parameter int ROM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_op_in,
    input  logic [4:0]  cmd_row_in,
    input  logic [5:0]  cmd_col_in,
    input  logic [7:0]  cmd_data_in,
    input  logic [11:0] cmd_src_in,
    input  logic [9:0]  cmd_len_in,
    output logic [11:0] menu_addr_out,
    input  logic [7:0]  menu_tile_in,
    output logic        buf_write_valid_out,
    output logic [9:0]  buf_write_addr_out,
    output logic [7:0]  buf_write_data_out,
    output logic        done_out,
    output logic        err_out
);

    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_CLEAR      = 3'd1;
    localparam logic [2:0] c_S_PUT        = 3'd2;
    localparam logic [2:0] c_S_COPY_ISSUE = 3'd3;
    localparam logic [2:0] c_S_COPY_DRAIN = 3'd4;
    localparam logic [2:0] c_S_DONE       = 3'd5;
    localparam logic [2:0] c_S_ERR        = 3'd6;

    localparam logic [1:0]  c_OP_CLEAR   = 2'd0;
    localparam logic [1:0]  c_OP_PUT     = 2'd1;
    localparam logic [1:0]  c_OP_COPY    = 2'd2;
    localparam logic [10:0] c_LAST       = 11'(COLS * ROWS - 1);
    localparam logic [9:0]  c_LAST10     = 10'(COLS * ROWS - 1);
    localparam logic [5:0]  c_ROWS       = 6'(ROWS);
    localparam logic [6:0]  c_COLS       = 7'(COLS);
    localparam logic [9:0]  c_COLS10     = 10'(COLS);
    localparam logic [1:0]  c_DRAIN_INIT = 2'(ROM_LATENCY - 1);

    logic [2:0]  r_state, w_state_nxt;
    logic        r_ready, r_done, r_err;
    logic [11:0] r_menu_addr, w_menu_addr;
    logic        r_wr_valid, w_wr_valid;
    logic [9:0]  r_wr_addr, w_wr_addr;
    logic [7:0]  r_wr_data, w_wr_data;
    logic [7:0]  r_fill, w_fill;
    logic [9:0]  r_rem, w_rem;
    logic [10:0] r_dst, w_dst, w_dst_inc;
    logic [1:0]  r_drain, w_drain;
    logic        w_pv0;
    logic [9:0]  w_pa0;
    logic [ROM_LATENCY-1:0]       r_pv;
    logic [ROM_LATENCY-1:0][9:0]  r_pa;

    logic        w_idle_like, w_bad;
    logic [9:0]  w_dest;

    assign w_idle_like = (r_state == c_S_IDLE) || (r_state == c_S_DONE) || (r_state == c_S_ERR);
    assign w_dest      = ({5'd0, cmd_row_in} * c_COLS10) + {4'd0, cmd_col_in};
    assign w_bad       = (cmd_op_in == 2'd3) ||
                         ((cmd_op_in != c_OP_CLEAR) &&
                          (({1'b0, cmd_row_in} >= c_ROWS) || ({1'b0, cmd_col_in} >= c_COLS)));
    // Saturates one past the last cell so long copies stay suppressed without wrapping.
    assign w_dst_inc   = (r_dst > c_LAST) ? r_dst : r_dst + 11'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= c_S_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_menu_addr <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_fill      <= '0;
            r_rem       <= '0;
            r_dst       <= '0;
            r_drain     <= '0;
            r_pv        <= '0;
            r_pa        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == c_S_IDLE) || (w_state_nxt == c_S_DONE) ||
                           (w_state_nxt == c_S_ERR);
            r_done      <= (w_state_nxt == c_S_DONE);
            r_err       <= (w_state_nxt == c_S_ERR);
            r_menu_addr <= w_menu_addr;
            r_wr_valid  <= w_wr_valid;
            r_wr_addr   <= w_wr_addr;
            r_wr_data   <= w_wr_data;
            r_fill      <= w_fill;
            r_rem       <= w_rem;
            r_dst       <= w_dst;
            r_drain     <= w_drain;
            r_pv[0]     <= w_pv0;
            r_pa[0]     <= w_pa0;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
            end
        end
    end

    // DONE and ERR behave as idle for acceptance so ready coincides with the pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_ERR: begin
                w_state_nxt = c_S_IDLE;
                if (cmd_valid_in) begin
                    if (w_bad)                         w_state_nxt = c_S_ERR;
                    else if (cmd_op_in == c_OP_CLEAR)  w_state_nxt = c_S_CLEAR;
                    else if (cmd_op_in == c_OP_PUT)    w_state_nxt = c_S_PUT;
                    else if (cmd_len_in == 10'd0)      w_state_nxt = c_S_PUT;
                    else                               w_state_nxt = c_S_COPY_ISSUE;
                end
            end
            c_S_CLEAR:      if (r_wr_addr == c_LAST10) w_state_nxt = c_S_DONE;
            c_S_PUT:        w_state_nxt = c_S_DONE;
            c_S_COPY_ISSUE: if (r_rem == 10'd0) w_state_nxt = c_S_COPY_DRAIN;
            c_S_COPY_DRAIN: if (r_drain == 2'd0) w_state_nxt = c_S_DONE;
            default:        w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_menu_addr = r_menu_addr;
        w_wr_valid  = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_wr_data   = r_wr_data;
        w_fill      = r_fill;
        w_rem       = r_rem;
        w_dst       = r_dst;
        w_drain     = r_drain;
        w_pv0       = 1'b0;
        w_pa0       = r_pa[0];
        if (r_pv[ROM_LATENCY-1]) begin
            w_wr_valid = 1'b1;
            w_wr_addr  = r_pa[ROM_LATENCY-1];
            w_wr_data  = menu_tile_in;
        end
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_ERR: begin
                if (cmd_valid_in && !w_bad) begin
                    case (cmd_op_in)
                        c_OP_CLEAR: begin
                            w_wr_valid = 1'b1;
                            w_wr_addr  = 10'd0;
                            w_wr_data  = cmd_data_in;
                            w_fill     = cmd_data_in;
                        end
                        c_OP_PUT: begin
                            w_wr_valid = 1'b1;
                            w_wr_addr  = w_dest;
                            w_wr_data  = cmd_data_in;
                        end
                        c_OP_COPY: begin
                            if (cmd_len_in != 10'd0) begin
                                w_menu_addr = cmd_src_in;
                                w_pv0       = 1'b1;
                                w_pa0       = w_dest;
                                w_dst       = {1'b0, w_dest};
                                w_rem       = cmd_len_in - 10'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            c_S_CLEAR: begin
                if (r_wr_addr != c_LAST10) begin
                    w_wr_valid = 1'b1;
                    w_wr_addr  = r_wr_addr + 10'd1;
                    w_wr_data  = r_fill;
                end
            end
            c_S_COPY_ISSUE: begin
                if (r_rem == 10'd0) begin
                    w_drain = c_DRAIN_INIT;
                end else begin
                    w_menu_addr = r_menu_addr + 12'd1;
                    w_dst       = w_dst_inc;
                    w_pv0       = (w_dst_inc <= c_LAST);
                    w_pa0       = w_dst_inc[9:0];
                    w_rem       = r_rem - 10'd1;
                end
            end
            c_S_COPY_DRAIN: begin
                if (r_drain != 2'd0) w_drain = r_drain - 2'd1;
            end
            default: ;
        endcase
    end

    assign cmd_ready_out       = r_ready;
    assign done_out            = r_done;
    assign err_out             = r_err;
    assign menu_addr_out       = r_menu_addr;
    assign buf_write_valid_out = r_wr_valid;
    assign buf_write_addr_out  = r_wr_addr;
    assign buf_write_data_out  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_config_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_text_writer
// Purpose  : Self-checking bench for config_text_writer against a command-level
//            model of expected buffer writes, done and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_text_writer;
    localparam int COLS  = 40;
    localparam int ROWS  = 23;
    localparam int LAT   = 2;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_row = '0;
    logic [5:0]  cmd_col = '0;
    logic [7:0]  cmd_data = '0;
    logic [11:0] cmd_src = '0;
    logic [9:0]  cmd_len = '0;
    logic [11:0] menu_addr;
    logic [7:0]  menu_tile;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {int cyc; int addr; int data;} wr_t;
    wr_t obs_w[$];
    wr_t exp_w[$];
    int  obs_d[$];
    bit  obs_drdy[$];
    int  obs_e[$];
    int  exp_d[$];
    int  exp_e[$];

    config_text_writer #(.COLS(COLS), .ROWS(ROWS), .ROM_LATENCY(LAT)) dut (
        .clk_in(clk), .rst_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
        .cmd_op_in(cmd_op), .cmd_row_in(cmd_row), .cmd_col_in(cmd_col),
        .cmd_data_in(cmd_data), .cmd_src_in(cmd_src), .cmd_len_in(cmd_len),
        .menu_addr_out(menu_addr), .menu_tile_in(menu_tile),
        .buf_write_valid_out(wr_valid), .buf_write_addr_out(wr_addr),
        .buf_write_data_out(wr_data), .done_out(done), .err_out(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM returns addr[7:0]; the DUT captures it at the edge closing cycle c+LAT-1,
    // so the resulting write is visible LAT cycles after the address.
    logic [7:0] rom_q = '0;
    always @(posedge clk) rom_q <= menu_addr[7:0];
    assign menu_tile = rom_q;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) obs_w.push_back('{cyc, int'(wr_addr), int'(wr_data)});
            if (done) begin
                obs_d.push_back(cyc);
                obs_drdy.push_back(cmd_ready);
            end
            if (err) obs_e.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        obs_w.delete(); obs_d.delete(); obs_drdy.delete(); obs_e.delete();
        exp_w.delete(); exp_d.delete(); exp_e.delete();
    endtask

    // Command-level reference: what the buffer must see for a command accepted in cycle t.
    task automatic build_exp(input int op, input int row, input int col, input int data,
                             input int src, input int len, input int t);
        bit bad = (op == 3) || (op != 0 && (row >= ROWS || col >= COLS));
        if (bad) begin
            exp_e.push_back(t + 1);
        end else if (op == 0) begin
            for (int a = 0; a < CELLS; a++) exp_w.push_back('{t + 1 + a, a, data & 255});
            exp_d.push_back(t + CELLS + 1);
        end else if (op == 1) begin
            exp_w.push_back('{t + 1, row * COLS + col, data & 255});
            exp_d.push_back(t + 2);
        end else begin
            for (int i = 0; i < len; i++) begin
                int a = row * COLS + col + i;
                if (a < CELLS) exp_w.push_back('{t + 1 + i + LAT, a, (src + i) & 255});
            end
            exp_d.push_back(len == 0 ? t + 2 : t + 1 + len + LAT);
        end
    endtask

    task automatic compare_all(input string tag);
        int bad = -1;
        chk({tag, " write count"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            if (obs_w[i].cyc != exp_w[i].cyc || obs_w[i].addr != exp_w[i].addr ||
                obs_w[i].data != exp_w[i].data) begin
                bad = i;
                break;
            end
        end
        chk({tag, " first bad write index"}, bad, -1);
        if (bad >= 0)
            chk($sformatf("%s write[%0d] cyc*2^20+addr*2^8+data", tag, bad),
                longint'(obs_w[bad].cyc) * 1048576 + obs_w[bad].addr * 256 + obs_w[bad].data,
                longint'(exp_w[bad].cyc) * 1048576 + exp_w[bad].addr * 256 + exp_w[bad].data);
        chk({tag, " done count"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s done[%0d] cycle", tag, i), obs_d[i], exp_d[i]);
            chk($sformatf("%s ready at done[%0d]", tag, i), obs_drdy[i], 1);
        end
        chk({tag, " err count"}, obs_e.size(), exp_e.size());
        for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++)
            chk($sformatf("%s err[%0d] cycle", tag, i), obs_e[i], exp_e[i]);
    endtask

    task automatic issue(input int op, input int row, input int col, input int data,
                         input int src, input int len, output int t);
        @(negedge clk);
        cmd_op = 2'(op); cmd_row = 5'(row); cmd_col = 6'(col);
        cmd_data = 8'(data); cmd_src = 12'(src); cmd_len = 10'(len);
        cmd_valid = 1'b1;
        t = -1;
        for (int k = 0; k < 2000; k++) begin
            if (cmd_ready) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("command accepted", t >= 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input int op, input int row, input int col,
                           input int data, input int src, input int len);
        int t;
        clear_logs();
        issue(op, row, col, data, src, len, t);
        for (int k = 0; k < 1100 + len; k++) begin
            if (obs_d.size() > 0 || obs_e.size() > 0) break;
            @(negedge clk); #1;
        end
        repeat (LAT + 3) @(negedge clk);
        #1;
        build_exp(op, row, col, data, src, len, t);
        compare_all(tag);
    endtask

    initial begin
        int t, last, op_r, row_r, col_r, len_r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ready", cmd_ready, 1);
        chk("reset write valid", wr_valid, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset menu addr", menu_addr, 0);
        chk("reset write addr", wr_addr, 0);

        run_cmd("clear 0x20", 0, 0, 0, 8'h20, 0, 0);
        run_cmd("put last cell", 1, 22, 39, 8'hAB, 0, 0);
        run_cmd("put row 23", 1, 23, 0, 8'h11, 0, 0);
        run_cmd("copy 0x100 x5", 2, 1, 38, 0, 12'h100, 5);
        run_cmd("copy tail suppress", 2, 22, 37, 0, int'($urandom_range(0, 4095)), 6);
        run_cmd("copy len 0", 2, 5, 5, 0, 12'h0FF, 0);
        run_cmd("reserved op", 3, 0, 0, 0, 0, 0);
        run_cmd("copy col 40", 2, 0, 40, 0, 0, 3);
        run_cmd("copy src wrap", 2, 10, 0, 0, 12'hFFE, 4);

        // Second command held on valid while CLEAR runs.
        clear_logs();
        @(negedge clk);
        cmd_op = 2'd0; cmd_data = 8'h33; cmd_valid = 1'b1;
        t = -1;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin t = cyc; break; end
            @(negedge clk);
        end
        chk("held clear accepted", t >= 0, 1);
        @(negedge clk);
        cmd_op = 2'd1; cmd_row = 5'd7; cmd_col = 6'd3; cmd_data = 8'hC4;
        for (int k = 0; k < 1000; k++) begin
            #1;
            if (obs_d.size() > 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #1;
        build_exp(0, 0, 0, 8'h33, 0, 0, t);
        build_exp(1, 7, 3, 8'hC4, 0, 0, t + CELLS + 1);
        compare_all("held valid");

        // Reset in the middle of a CLEAR.
        clear_logs();
        issue(0, 0, 0, 8'h5A, 0, 0, t);
        for (int k = 0; k < 300; k++) begin
            #1;
            if (obs_w.size() > 0 && obs_w[$].addr >= 100) break;
            @(negedge clk);
        end
        last = (obs_w.size() > 0) ? obs_w[$].addr : -1;
        chk("mid-clear write index", last, 100);
        rst = 1'b1;
        #1;
        chk("async valid drop", wr_valid, 0);
        chk("ready in reset", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (930) @(negedge clk);
        #1;
        chk("writes after reset", obs_w.size(), 0);
        chk("done after reset", obs_d.size(), 0);
        chk("ready after reset", cmd_ready, 1);
        run_cmd("put after reset", 1, 4, 9, 8'h77, 0, 0);

        for (int n = 0; n < 25; n++) begin
            op_r  = int'($urandom_range(0, 19));
            op_r  = (op_r == 0) ? 0 : (op_r < 9) ? 1 : (op_r < 18) ? 2 : 3;
            row_r = int'($urandom_range(0, 24));
            col_r = int'($urandom_range(0, 41));
            len_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60))
                                                : int'($urandom_range(0, 8));
            run_cmd($sformatf("random %0d op%0d", n, op_r), op_r, row_r, col_r,
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)), len_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/config_text_writer.md
Name: config_text_writer

Overview:
- Command-driven sequencer that fills the 40x23 configuration tile buffer (8-bit tile indices, 10-bit write address).
- Executes three operations: clear the buffer, put a single tile, or copy a string of tile indices from the menu-name ROM (read port, 12-bit address) into the buffer.
- Sits between the config menu FSM (command issuer) and the memory block. It drives the buffer write port and the menu ROM address port, and consumes the ROM read data.

Parameters:
- COLS, 40, buffer columns
- ROWS, 23, buffer rows
- ROM_LATENCY, 2, cycles from menu_addr_out to valid menu_tile_in (1 or 2 supported)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- cmd_valid_in  input  1  command present
- cmd_ready_out  output  1  block idle, able to accept a command
- cmd_op_in  input  2  0=CLEAR, 1=PUT, 2=COPY, 3=reserved (error)
- cmd_row_in  input  5  destination row (PUT/COPY)
- cmd_col_in  input  6  destination column (PUT/COPY)
- cmd_data_in  input  8  tile for PUT, fill tile for CLEAR
- cmd_src_in  input  12  menu ROM start address (COPY)
- cmd_len_in  input  10  tile count (COPY)
- menu_addr_out  output  12  menu ROM read address
- menu_tile_in  input  8  menu ROM read data
- buf_write_valid_out  output  1  buffer write enable
- buf_write_addr_out  output  10  buffer write address
- buf_write_data_out  output  8  buffer write data
- done_out  output  1  one-cycle pulse: command finished
- err_out  output  1  one-cycle pulse: command rejected

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready_out=1; all other outputs 0; pipeline flushed. Reset mid-command aborts it, with no further writes and no done pulse.
- Accept on cmd_valid_in && cmd_ready_out (cycle T). cmd_ready_out=1 only in IDLE; it drops at T+1. Inputs are sampled only at T.
- Destination address = row*COLS+col, computed in 10 bits. All outputs are registered.
- Validation at T: an op of 3, or row>=ROWS or col>=COLS for PUT/COPY, gives err_out=1 at T+1, no writes, no done, and a return to IDLE (ready at T+1).
- CLEAR: writes addresses 0..COLS*ROWS-1 (0..919) with cmd_data_in, one per cycle, cycles T+1..T+920. done_out at T+921, and IDLE/ready on the same cycle.
- PUT: single write at T+1. done_out at T+2.
- COPY, len L>0:
  - menu_addr_out = src+i at cycle T+1+i for i=0..L-1, with 12-bit wrap.
  - Write i occurs at T+1+i+ROM_LATENCY with data menu_tile_in and address dest+i. Rows wrap implicitly (linear address).
  - A delay line of ROM_LATENCY stages carries the valid bit and destination address alongside the ROM access.
  - Writes whose address would exceed COLS*ROWS-1 are suppressed (valid=0), but the sequence still runs to length L.
  - done_out is asserted on the cycle after the last issued slot drains: T+1+L+ROM_LATENCY.
- COPY, L=0: no ROM reads, no writes, done_out at T+2.
- States: IDLE, CLEAR, PUT, COPY_ISSUE, COPY_DRAIN, DONE (one cycle, pulses done_out, then IDLE), ERR (one cycle, pulses err_out).
- menu_addr_out holds its last value outside COPY_ISSUE. buf_write_addr_out and buf_write_data_out hold their last value when valid=0.
- cmd_valid_in while busy is ignored. The issuer must hold it until ready.
- At most one write per cycle; no back-pressure on the write port.

Test Plan:
- Reset, then CLEAR with data=0x20: exactly 920 writes, addr 0..919 consecutive, data 0x20, first write at T+1, done_out only at T+921, ready returns the same cycle.
- PUT row=22 col=39 data=0xAB: one write addr=919 data=0xAB at T+1, done at T+2. A second PUT with row=23 gives err_out at T+1, no write, no done.
- COPY src=0x100 len=5 row=1 col=38, ROM model latency 2 returning addr[7:0]: menu_addr 0x100..0x104 at T+1..T+5; writes addr 78..82 data 0x00..0x04 at T+3..T+7; done at T+8.
- COPY row=22 col=37 len=6: writes only at 917, 918, 919; the last 3 slots are suppressed; done at T+1+6+2.
- COPY len=0: no writes, done at T+2. cmd_valid_in held high during a CLEAR: the second command is accepted only after done/ready, with no overlap.
- Assert rst_in mid-CLEAR at write 100: buf_write_valid_out drops asynchronously, no done, ready=1 after release, and a new PUT executes normally.
